// File: rtl/pic_pkg.sv
// Shared constants and helpers for the PIC request-register blocks.
package pic_pkg;

  localparam int PIC_N_IRQ       = 8;
  localparam int PIC_SYNC_STAGES = 2;

  // Values carried on the ltim pin.
  localparam logic LTIM_EDGE  = 1'b0;
  localparam logic LTIM_LEVEL = 1'b1;

  // Width of a channel index. Never below one bit, so a 2-channel block
  // still has a usable index port.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irr_prio_resolver.sv
// Rotating-priority resolver: rotate irr so prio_base lands at slot 0, pick
// the lowest set slot, then map that slot back to a channel index.
module irr_prio_resolver import pic_pkg::*; #(
  parameter int  N_IRQ = PIC_N_IRQ,
  localparam int IDW   = idx_width(N_IRQ)
) (
  input  logic [N_IRQ-1:0] irr,
  input  logic [IDW-1:0]   prio_base,
  output logic [IDW-1:0]   win_id,
  output logic             any
);

  int               base;
  int               first;
  int               wid;
  logic [N_IRQ-1:0] rot;

  // Fold a base that points past the last channel back into range; the index
  // port can encode values up to 2*N_IRQ-1 at most, so one subtract suffices.
  always_comb begin
    base = int'(prio_base);
    if (base >= N_IRQ) base = base - N_IRQ;
  end

  // Rotate: slot k holds channel (base + k) mod N_IRQ.
  always_comb begin
    int idx;
    rot = '0;
    idx = 0;
    for (int k = 0; k < N_IRQ; k++) begin
      idx = base + k;
      if (idx >= N_IRQ) idx = idx - N_IRQ;
      rot[k] = irr[idx];
    end
  end

  // Find-first from slot 0 upward; scanning downward lets the lowest slot win.
  always_comb begin
    first = 0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (rot[k]) first = k;
    end
  end

  // Unrotate the winning slot back to a channel number.
  always_comb begin
    wid = base + first;
    if (wid >= N_IRQ) wid = wid - N_IRQ;
    win_id = IDW'(wid);
    any    = |irr;
  end

endmodule

// File: rtl/irr_param.sv
// Interrupt request register: synchronises the request lines, latches them in
// edge or level mode, clears on acknowledge and registers the resolved winner.
module irr_param import pic_pkg::*; #(
  parameter int  N_IRQ       = PIC_N_IRQ,
  parameter int  SYNC_STAGES = PIC_SYNC_STAGES,
  localparam int IDW         = idx_width(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ltim,
  input  logic [N_IRQ-1:0] mask,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             ack,
  input  logic [IDW-1:0]   ack_id,
  input  logic [IDW-1:0]   prio_base,
  output logic [N_IRQ-1:0] irr,
  output logic             int_req,
  output logic [IDW-1:0]   int_id
);

  // Stage 0 takes irq_in; stage SYNC_STAGES-1 is the synchronised value.
  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q, sync_d;
  logic [N_IRQ-1:0]                  p_q, p_d;
  logic [N_IRQ-1:0]                  irr_q, irr_d;
  logic                              ltim_q, ltim_d;
  logic                              int_req_q, int_req_d;
  logic [IDW-1:0]                    int_id_q, int_id_d;

  logic [N_IRQ-1:0] s;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] edge_nxt;
  logic             ltim_chg;
  logic [IDW-1:0]   win_id;
  logic             win_any;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~p_q;
  assign ltim_chg = ltim ^ ltim_q;

  // Shift the synchroniser; the previous-sample flop always tracks s, which
  // also makes lines that are already high at a mode switch look edge-free.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
    p_d    = s;
    ltim_d = ltim;
  end

  // Edge-mode next state per channel: mask beats a new edge, a new edge beats
  // an acknowledge of the same channel. Out-of-range ack_id matches nothing.
  always_comb begin
    edge_nxt = irr_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (mask[i])                           edge_nxt[i] = 1'b0;
      else if (rise[i])                      edge_nxt[i] = 1'b1;
      else if (ack && (ack_id == IDW'(i)))   edge_nxt[i] = 1'b0;
    end
  end

  // Request register: a mode change flushes everything for one cycle, then
  // the registered mode selects level tracking or edge latching.
  always_comb begin
    irr_d = irr_q;
    if (ltim_chg)                  irr_d = '0;
    else if (ltim_q == LTIM_LEVEL) irr_d = s & ~mask;
    else                           irr_d = edge_nxt;
  end

  irr_prio_resolver #(.N_IRQ(N_IRQ)) u_res (
    .irr       (irr_q),
    .prio_base (prio_base),
    .win_id    (win_id),
    .any       (win_any)
  );

  // Registered interrupt outputs; int_id keeps its last winner when idle.
  always_comb begin
    int_req_d = win_any;
    int_id_d  = win_any ? win_id : int_id_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      p_q       <= '0;
      ltim_q    <= LTIM_EDGE;
      irr_q     <= '0;
      int_req_q <= 1'b0;
      int_id_q  <= '0;
    end else begin
      sync_q    <= sync_d;
      p_q       <= p_d;
      ltim_q    <= ltim_d;
      irr_q     <= irr_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
    end
  end

  assign irr     = irr_q;
  assign int_req = int_req_q;
  assign int_id  = int_id_q;

endmodule
